watch_display_scan: RTL
=======================

Name: watch_display_scan

Overview:
- Display stage directly downstream of the watch's seconds/minutes/hours counters.
- Takes the three binary counts (0..59 / 0..23), converts each to two BCD digits and time-multiplexes six common-anode 7-segment digits.
- Blinks the field selected for time-setting.
- Snapshots all three counts once per frame so a carry ripple never shows a torn time.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; minimum 2.
- BLINK_TICKS, 250, digit slots per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- sec_num  input  8  seconds count, binary.
- min_num  input  8  minutes count, binary.
- hour_num  input  8  hours count, binary.
- set_sel  input  2  field being set: 00 none, 01 seconds, 10 minutes, 11 hours.
- seg  output  8  segments, active-low; seg[0]=a .. seg[6]=g, seg[7]=dp.
- dig_sel  output  6  digit enables, active-low one-hot; bit n = digit n.

Behaviour:
- Reset (async, RESET=1), all registered:
  - seg=8'hFF, dig_sel=6'b111111.
  - Prescaler=0, digit index=0, blink counter=0, blink phase=visible.
  - Snapshot registers=0.
- Prescaler counts 0..SCAN_DIV-1. scan_tick is the cycle it equals SCAN_DIV-1; it then wraps to 0.
- On each scan_tick, digit index advances 5->0 with wrap; all other steps +1.
- Digit map:
  - 0 = sec units, 1 = sec tens.
  - 2 = min units, 3 = min tens.
  - 4 = hour units, 5 = hour tens.
- Snapshot:
  - On the scan_tick where the index wraps 5->0, sec/min/hour inputs are latched.
  - Digits 0..5 of that frame come only from the latched copy.
  - Inputs changing mid-frame do not affect the current frame.
- Conversion: value v in 0..99 gives tens=v/10, units=v%10, no leading-zero suppression. v>99 shows both digits of that field as dash.
- Glyphs (seg, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - dash=BF, blank=FF.
- Decimal point: seg[7]=0 on digits 2 and 4 (separators), unless that digit is blanked.
- Blink:
  - Blink counter increments on each scan_tick.
  - On reaching BLINK_TICKS-1 it wraps to 0 and toggles the phase.
  - While phase=hidden and set_sel selects a field, both digits of that field output FF (dp also off).
  - set_sel=00 never blanks.
  - Changing set_sel resets neither counter nor phase.
- Anti-ghosting and latency:
  - In the clk cycle after scan_tick: dig_sel=6'b111111 and seg=FF.
  - In the following cycle: dig_sel drives the new digit and seg its glyph.
  - These values hold until the next scan_tick.
  - Each slot is therefore SCAN_DIV cycles: 1 dark cycle plus SCAN_DIV-1 lit cycles.
- Out of reset, the first lit digit is digit 1, reached after the first scan_tick. Digit 0 is first shown after the 5->0 wrap.
- Reset mid-frame: outputs go dark immediately (async). Scanning resumes from the reset state on RESET deassertion.
- Only one dig_sel bit is low at any time; there is never more than one.

Test Plan:
(All scenarios use SCAN_DIV=4, BLINK_TICKS=3.)
1. Reset held, then released with sec=0, min=0, hour=0 -> seg=FF/dig_sel=3F during reset. Dark cycle after each tick. Full frame shows C0 on every digit; digits 2 and 4 show 40.
2. sec=37, min=5, hour=23 latched at wrap -> per slot, digit0..5 show:
   - digit0 F8 (dig_sel 3E)
   - digit1 B0
   - digit2 12 (5 with dp)
   - digit3 C0
   - digit4 30 (3 with dp)
   - digit5 A4
3. sec changes 37->38 while digit 2 is lit -> current frame still shows sec 37. Next frame shows units 80 (8).
4. set_sel=10, count ticks -> digits 2/3 are FF for 3 slots, visible for 3 slots, repeating. Digits 0,1,4,5 are unaffected. set_sel=00 -> never blanked.
5. hour=8'd120 -> digits 4/5 show dash: digit4 = 3F (dash with dp), digit5 = BF.
6. Assert RESET while digit 3 is lit -> same-cycle dig_sel=3F, seg=FF. After release, the sequence restarts exactly as in scenario 1. The bench checks that at most one dig_sel bit is low in every cycle of all scenarios.

Source files
------------

// File: rtl/watch_display_scan.sv
// Six-digit multiplexed 7-segment driver for the watch time counters.
// Converts seconds/minutes/hours to BCD, scans common-anode digits with a
// dark guard cycle between slots, blinks the field being set, and takes a
// per-frame snapshot of the counts so a carry ripple never tears the display.
module watch_display_scan #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] sec_num,
    input  logic [7:0] min_num,
    input  logic [7:0] hour_num,
    input  logic [1:0] set_sel,
    output logic [7:0] seg,
    output logic [5:0] dig_sel
);

    localparam int unsigned PreW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PreW-1:0]   PreLast   = PreW'(SCAN_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    // StIdle: dark until the first tick; StDark: guard cycle; StLit: digit on.
    typedef enum logic [1:0] {StIdle, StDark, StLit} slot_state_e;

    slot_state_e       state_q;
    logic [PreW-1:0]   prescaler_q;
    logic [2:0]        dig_idx_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_hidden_q;
    logic [7:0]        sec_snap_q;
    logic [7:0]        min_snap_q;
    logic [7:0]        hour_snap_q;

    logic              scan_tick;
    logic              frame_wrap;
    logic [7:0]        field_val;
    logic [7:0]        tens8;
    logic [7:0]        units8;
    logic [7:0]        digit8;
    logic [7:0]        glyph;
    logic [1:0]        field_code;
    logic              dp_on;
    logic              blank;
    logic [7:0]        seg_d;
    logic [5:0]        dig_sel_d;

    assign scan_tick  = (prescaler_q == PreLast);
    assign frame_wrap = scan_tick && (dig_idx_q == 3'd5);

    // Digit glyphs, active-low, dp bit left off.
    function automatic logic [7:0] seg_lut(input logic [7:0] d);
        logic [7:0] g;
        case (d)
            8'd0:    g = 8'hC0;
            8'd1:    g = 8'hF9;
            8'd2:    g = 8'hA4;
            8'd3:    g = 8'hB0;
            8'd4:    g = 8'h99;
            8'd5:    g = 8'h92;
            8'd6:    g = 8'h82;
            8'd7:    g = 8'hF8;
            8'd8:    g = 8'h80;
            8'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Slot prescaler: one scan_tick every SCAN_DIV clocks.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            prescaler_q <= '0;
        end else if (scan_tick) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + 1'b1;
        end
    end

    // Digit index 0..5, advanced once per slot.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            dig_idx_q <= 3'd0;
        end else if (scan_tick) begin
            dig_idx_q <= (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
        end
    end

    // Latch all three counts together at the frame boundary.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sec_snap_q  <= 8'd0;
            min_snap_q  <= 8'd0;
            hour_snap_q <= 8'd0;
        end else if (frame_wrap) begin
            sec_snap_q  <= sec_num;
            min_snap_q  <= min_num;
            hour_snap_q <= hour_num;
        end
    end

    // Blink timebase counted in slots; independent of set_sel.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_q    <= '0;
                blink_hidden_q <= ~blink_hidden_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Glyph for the digit about to be lit, from the snapshot only.
    always_comb begin
        field_val = sec_snap_q;
        unique case (dig_idx_q[2:1])
            2'd1:    field_val = min_snap_q;
            2'd2:    field_val = hour_snap_q;
            default: field_val = sec_snap_q;
        endcase
        tens8      = field_val / 8'd10;
        units8     = field_val % 8'd10;
        digit8     = dig_idx_q[0] ? tens8 : units8;
        glyph      = (field_val > 8'd99) ? 8'hBF : seg_lut(digit8);
        // set_sel codes are field index + 1 (00 means nothing selected).
        field_code = dig_idx_q[2:1] + 2'd1;
        blank      = blink_hidden_q && (set_sel != 2'b00) && (set_sel == field_code);
        dp_on      = (dig_idx_q == 3'd2) || (dig_idx_q == 3'd4);
        seg_d      = blank ? 8'hFF : (glyph & {~dp_on, 7'h7F});
        dig_sel_d  = ~(6'b000001 << dig_idx_q);
    end

    // Output sequencer: tick -> one dark cycle -> lit until the next tick.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            seg     <= 8'hFF;
            dig_sel <= 6'b111111;
        end else if (scan_tick) begin
            state_q <= StDark;
            seg     <= 8'hFF;
            dig_sel <= 6'b111111;
        end else begin
            case (state_q)
                StDark: begin
                    state_q <= StLit;
                    seg     <= seg_d;
                    dig_sel <= dig_sel_d;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule
